// File: rtl/dma_multi_ch_ctrl_pkg.sv
// dma_multi_ch_ctrl_pkg: register map, bit positions and channel state type
package dma_multi_ch_ctrl_pkg;
    localparam int DMA_NUM_CH = 4;
    localparam int CH_STRIDE = 'h20;
    localparam logic [4:0] OFF_SRC = 5'h00, OFF_DST = 5'h04, OFF_SIZE = 5'h08, OFF_CTRL = 5'h0C, OFF_STATUS = 5'h10;
    localparam int ADDR_INTR_STATUS = 'h100, ADDR_INTR_EN = 'h104;
    localparam int CTRL_START = 0, CTRL_MODE = 1;
    localparam int STATUS_BUSY = 0, STATUS_DONE = 1, STATUS_ERR = 2;
    typedef enum logic [1:0] {CH_IDLE, CH_PENDING, CH_ACTIVE} ch_state_e;
    function automatic int ch_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/dma_multi_ch_ctrl_if.sv
// dma_multi_ch_ctrl_if: APB register port plus downstream engine command port
interface dma_multi_ch_ctrl_if
    import dma_multi_ch_ctrl_pkg::*;
#(
    parameter int NUM_CH = DMA_NUM_CH,
    parameter int REG_ADDR_WIDTH = 32,
    parameter int REG_DATA_WIDTH = 32,
    parameter int MEM_DATA_WIDTH = 32
);
    localparam int CW = ch_w(NUM_CH);
    logic PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [REG_ADDR_WIDTH-1:0] PADDR;
    logic [REG_DATA_WIDTH-1:0] PWDATA, PRDATA;
    logic eng_valid, eng_ready, eng_done, eng_err, INTR;
    logic [CW-1:0] eng_ch;
    logic [MEM_DATA_WIDTH-1:0] eng_src, eng_dst, eng_size;
    logic [1:0] eng_mode;
    modport slave (
        input PSEL, PENABLE, PWRITE, PADDR, PWDATA, eng_ready, eng_done, eng_err,
        output PREADY, PRDATA, PSLVERR, eng_valid, eng_ch, eng_src, eng_dst, eng_size, eng_mode, INTR
    );
    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, eng_ready, eng_done, eng_err,
        input PREADY, PRDATA, PSLVERR, eng_valid, eng_ch, eng_src, eng_dst, eng_size, eng_mode, INTR
    );
endinterface

// File: rtl/dma_rr_arbiter.sv
// dma_rr_arbiter: round-robin grant starting after the last granted index
module dma_rr_arbiter
    import dma_multi_ch_ctrl_pkg::*;
#(
    parameter int NUM_CH = DMA_NUM_CH,
    localparam int CW = ch_w(NUM_CH)
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic [NUM_CH-1:0] req,
    input  logic              en,
    output logic [NUM_CH-1:0] gnt,
    output logic [CW-1:0]     idx
);
    logic [CW-1:0] ptr, k;
    logic found;
    always_comb begin
        gnt = '0;
        idx = '0;
        found = 1'b0;
        k = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            k = CW'((int'(ptr) + i) % NUM_CH);
            if (en && !found && req[k]) begin
                found = 1'b1;
                gnt[k] = 1'b1;
                idx = k;
            end
        end
    end
    always_ff @(posedge CLK) begin
        if (!RSTN) ptr <= CW'(NUM_CH - 1);
        else if (found) ptr <= idx;
    end
endmodule

// File: rtl/dma_multi_ch_ctrl.sv
// dma_multi_ch_ctrl: APB-programmed multi-channel DMA control with round-robin dispatch
module dma_multi_ch_ctrl
    import dma_multi_ch_ctrl_pkg::*;
#(
    parameter int NUM_CH = DMA_NUM_CH,
    parameter int REG_ADDR_WIDTH = 32,
    parameter int REG_DATA_WIDTH = 32,
    parameter int MEM_DATA_WIDTH = 32
) (
    input logic CLK,
    input logic RSTN,
    dma_multi_ch_ctrl_if.slave bus
);
    localparam int CW = ch_w(NUM_CH);
    ch_state_e st[NUM_CH];
    logic [MEM_DATA_WIDTH-1:0] src[NUM_CH], dst[NUM_CH], size[NUM_CH];
    logic [1:0] mode[NUM_CH];
    logic [NUM_CH-1:0] done, err, intr_status, intr_en, pend, set, w1c, gnt, start;
    logic [CW-1:0] gidx;
    logic acc, wr, in_ch, off_ok, is_is, is_en, sel_busy, any_act, ch_we, err_resp;
    logic [2:0] ch_sel, stw, ctw;
    logic [4:0] off;
    logic [1:0] new_mode;
    logic [REG_DATA_WIDTH-1:0] rdata;
    always_comb begin
        acc = bus.PSEL && bus.PENABLE && !bus.PREADY;
        wr = acc && bus.PWRITE;
        ch_sel = bus.PADDR[7:5];
        off = bus.PADDR[4:0];
        in_ch = bus.PADDR < REG_ADDR_WIDTH'(NUM_CH * CH_STRIDE);
        off_ok = off inside {OFF_SRC, OFF_DST, OFF_SIZE, OFF_CTRL, OFF_STATUS};
        is_is = bus.PADDR == REG_ADDR_WIDTH'(ADDR_INTR_STATUS);
        is_en = bus.PADDR == REG_ADDR_WIDTH'(ADDR_INTR_EN);
        new_mode = bus.PWDATA[CTRL_MODE +: 2];
        sel_busy = 1'b0;
        any_act = 1'b0;
        pend = '0;
        stw = '0;
        ctw = '0;
        rdata = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            pend[c] = st[c] == CH_PENDING;
            any_act |= st[c] == CH_ACTIVE;
            if (ch_sel == 3'(c)) begin
                sel_busy = st[c] != CH_IDLE;
                stw[STATUS_BUSY] = st[c] != CH_IDLE;
                stw[STATUS_DONE] = done[c];
                stw[STATUS_ERR] = err[c];
                ctw[CTRL_MODE +: 2] = mode[c];
                rdata = off == OFF_SRC ? REG_DATA_WIDTH'(src[c]) :
                        off == OFF_DST ? REG_DATA_WIDTH'(dst[c]) :
                        off == OFF_SIZE ? REG_DATA_WIDTH'(size[c]) :
                        off == OFF_CTRL ? REG_DATA_WIDTH'(ctw) : REG_DATA_WIDTH'(stw);
            end
        end
        rdata = (in_ch && off_ok) ? rdata : is_is ? REG_DATA_WIDTH'(intr_status) :
                is_en ? REG_DATA_WIDTH'(intr_en) : '0;
        ch_we = wr && in_ch && off_ok && !sel_busy;
        err_resp = !((in_ch && off_ok) || is_is || is_en) ||
                   (in_ch && off_ok && bus.PWRITE && sel_busy && off != OFF_STATUS);
        w1c = (wr && is_is) ? bus.PWDATA[NUM_CH-1:0] : '0;
        for (int c = 0; c < NUM_CH; c++) begin
            start[c] = ch_we && ch_sel == 3'(c) && off == OFF_CTRL && bus.PWDATA[CTRL_START];
            set[c] = (start[c] && (new_mode == 2'd0 || size[c] == '0)) ||
                     (bus.eng_done && st[c] == CH_ACTIVE);
        end
    end
    dma_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .CLK(CLK), .RSTN(RSTN), .req(pend), .en(!any_act && !bus.eng_valid), .gnt(gnt), .idx(gidx)
    );
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            bus.PREADY <= 1'b0;
            bus.PRDATA <= '0;
            bus.PSLVERR <= 1'b0;
            bus.eng_valid <= 1'b0;
            bus.eng_ch <= '0;
            bus.eng_src <= '0;
            bus.eng_dst <= '0;
            bus.eng_size <= '0;
            bus.eng_mode <= '0;
            bus.INTR <= 1'b0;
            intr_status <= '0;
            intr_en <= '0;
            done <= '0;
            err <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                st[c] <= CH_IDLE;
                src[c] <= '0;
                dst[c] <= '0;
                size[c] <= '0;
                mode[c] <= '0;
            end
        end else begin
            bus.PREADY <= acc;
            bus.PSLVERR <= acc && err_resp;
            bus.PRDATA <= (acc && !bus.PWRITE) ? rdata : '0;
            bus.INTR <= |(intr_status & intr_en);
            // a hardware completion in the same cycle as a clear keeps the bit set
            intr_status <= (intr_status & ~w1c) | set;
            if (wr && is_en) intr_en <= bus.PWDATA[NUM_CH-1:0];
            if (bus.eng_valid && bus.eng_ready) bus.eng_valid <= 1'b0;
            if (|gnt) begin
                bus.eng_valid <= 1'b1;
                bus.eng_ch <= gidx;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_we && ch_sel == 3'(c)) begin
                    if (off == OFF_SRC) src[c] <= MEM_DATA_WIDTH'(bus.PWDATA);
                    if (off == OFF_DST) dst[c] <= MEM_DATA_WIDTH'(bus.PWDATA);
                    if (off == OFF_SIZE) size[c] <= MEM_DATA_WIDTH'(bus.PWDATA);
                    if (off == OFF_CTRL) mode[c] <= new_mode;
                end
                if (start[c]) begin
                    done[c] <= new_mode == 2'd0 || size[c] == '0;
                    err[c] <= new_mode == 2'd0;
                    st[c] <= (new_mode != 2'd0 && size[c] != '0) ? CH_PENDING : CH_IDLE;
                end
                if (bus.eng_done && st[c] == CH_ACTIVE) begin
                    st[c] <= CH_IDLE;
                    done[c] <= 1'b1;
                    err[c] <= bus.eng_err;
                end
                if (gnt[c]) begin
                    st[c] <= CH_ACTIVE;
                    bus.eng_src <= src[c];
                    bus.eng_dst <= dst[c];
                    bus.eng_size <= size[c];
                    bus.eng_mode <= mode[c];
                end
            end
        end
    end
endmodule
